// File: rtl/ysyx_23060072_hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: FSM state encoding and PC width default.
package ysyx_23060072_hazard_ctrl_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_TRAP     = 2'd3
  } state_e;

endpackage

// File: rtl/ysyx_23060072_scoreboard.sv
// Per-register pending-write counters for long-latency writers, with RAW lookup and retire bypass.
module ysyx_23060072_scoreboard #(
  parameter  int unsigned REG_NUM = 16,
  parameter  int unsigned PEND_W  = 2,
  localparam int unsigned AW      = $clog2(REG_NUM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_en_i,
  input  logic [AW-1:0] inc_idx_i,
  input  logic          dec_en_i,
  input  logic [AW-1:0] dec_idx_i,
  input  logic          rs1_en_i,
  input  logic [AW-1:0] rs1_i,
  input  logic          rs2_en_i,
  input  logic [AW-1:0] rs2_i,
  input  logic [AW-1:0] rd_i,
  output logic          rs1_hazard_o,
  output logic          rs2_hazard_o,
  output logic          rd_sat_o,
  output logic          all_clear_o
);

  logic [PEND_W-1:0] pend_q [REG_NUM];
  logic [PEND_W-1:0] pend_d [REG_NUM];

  // Entry 0 is never written, so x0 reads as permanently clear.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned r = 1; r < REG_NUM; r++) begin
      if (inc_en_i && inc_idx_i == AW'(r) &&
          !(dec_en_i && dec_idx_i == AW'(r) && pend_q[r] != '0)) begin
        pend_d[r] = pend_q[r] + 1'b1;
      end else if (dec_en_i && dec_idx_i == AW'(r) && pend_q[r] != '0 &&
                   !(inc_en_i && inc_idx_i == AW'(r))) begin
        pend_d[r] = pend_q[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '{default: '0};
    end else begin
      pend_q <= pend_d;
    end
  end

  // A retiring last outstanding write releases its readers in the same cycle.
  assign rs1_hazard_o = rs1_en_i && (rs1_i != '0) && (pend_q[rs1_i] != '0) &&
                        !(dec_en_i && dec_idx_i == rs1_i && pend_q[rs1_i] == PEND_W'(1));
  assign rs2_hazard_o = rs2_en_i && (rs2_i != '0) && (pend_q[rs2_i] != '0) &&
                        !(dec_en_i && dec_idx_i == rs2_i && pend_q[rs2_i] == PEND_W'(1));
  assign rd_sat_o     = (rd_i != '0) && (pend_q[rd_i] == '1);

  always_comb begin
    all_clear_o = 1'b1;
    for (int unsigned r = 1; r < REG_NUM; r++) begin
      if (pend_q[r] != '0) all_clear_o = 1'b0;
    end
  end

  retire_without_pending: assert property (
    @(posedge clk) disable iff (rst) dec_en_i |-> (pend_q[dec_idx_i] != '0)
  );

endmodule

// File: rtl/ysyx_23060072_hazard_ctrl.sv
// Stall/flush/redirect control for the 5-stage core: scoreboarded RAW stalls, mispredict redirect, drain-then-trap.
module ysyx_23060072_hazard_ctrl
  import ysyx_23060072_hazard_ctrl_pkg::*;
#(
  parameter  int unsigned REG_NUM = 16,
  parameter  int unsigned PEND_W  = 2,
  parameter  int unsigned XLEN    = XLEN_DEFAULT,
  localparam int unsigned AW      = $clog2(REG_NUM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic            id_rs1_en,
  input  logic [AW-1:0]   id_rs1,
  input  logic            id_rs2_en,
  input  logic [AW-1:0]   id_rs2,
  input  logic            id_wb_en,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_long,
  input  logic            wb_long,
  input  logic [AW-1:0]   wb_rd,
  input  logic            predict_flag,
  input  logic            ex_jump_flag,
  input  logic [XLEN-1:0] ex_jump_pc,
  input  logic            clint_req,
  input  logic [XLEN-1:0] clint_pc,
  input  logic            md_busy,
  input  logic            lsu_busy,
  output logic            if_hold,
  output logic            id_hold,
  output logic            ex_hold,
  output logic            clean_flag,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            clint_ack,
  output logic            raw_stall
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] target_q, target_d;

  logic rs1_hazard, rs2_hazard, rd_sat, all_clear;
  logic issue, inc_en, dec_en, busy;

  assign busy   = lsu_busy | md_busy;
  assign issue  = id_valid & ~id_hold & ~clean_flag;
  assign inc_en = issue & id_long & id_wb_en & (id_rd != '0);
  assign dec_en = wb_long & (wb_rd != '0);

  ysyx_23060072_scoreboard #(
    .REG_NUM (REG_NUM),
    .PEND_W  (PEND_W)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .inc_en_i     (inc_en),
    .inc_idx_i    (id_rd),
    .dec_en_i     (dec_en),
    .dec_idx_i    (wb_rd),
    .rs1_en_i     (id_rs1_en),
    .rs1_i        (id_rs1),
    .rs2_en_i     (id_rs2_en),
    .rs2_i        (id_rs2),
    .rd_i         (id_rd),
    .rs1_hazard_o (rs1_hazard),
    .rs2_hazard_o (rs2_hazard),
    .rd_sat_o     (rd_sat),
    .all_clear_o  (all_clear)
  );

  assign raw_stall = id_valid & (rs1_hazard | rs2_hazard | (id_long & id_wb_en & rd_sat));

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    if_hold        = 1'b0;
    id_hold        = 1'b0;
    ex_hold        = 1'b0;
    clean_flag     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    clint_ack      = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (busy) begin
          if_hold = 1'b1;
          id_hold = 1'b1;
          ex_hold = 1'b1;
        end else if (raw_stall) begin
          if_hold    = 1'b1;
          id_hold    = 1'b1;
          clean_flag = 1'b1;
        end
        // Taken or not, EX supplies the correct PC on ex_jump_pc; a trap request discards the jump.
        if (clint_req) begin
          state_d = ST_DRAIN;
        end else if (ex_jump_flag ^ predict_flag) begin
          state_d  = ST_REDIRECT;
          target_d = ex_jump_pc;
        end
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        clean_flag     = 1'b1;
        state_d        = ST_RUN;
      end
      ST_DRAIN: begin
        if_hold    = 1'b1;
        id_hold    = 1'b1;
        ex_hold    = busy;
        clean_flag = 1'b1;
        if (all_clear && !busy) state_d = ST_TRAP;
      end
      ST_TRAP: begin
        redirect_valid = 1'b1;
        redirect_pc    = clint_pc;
        clint_ack      = 1'b1;
        clean_flag     = 1'b1;
        state_d        = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

endmodule
